baser_test_sequencer: RTL and testbench

Run-time controller for the BASE-R generator/257b-checker loop. It steps the generator through a programmed list of data-select patterns and drives the generator enable/valid. For each step it snapshots the checker's cumulative block and invalid-block counters and judges the step pass/fail. It sits beside the PCS generator and the BASE-R 257b checker, replacing hand-timed bench stimulus with a self-sequencing test run.

---
 rtl/baser_pkg.sv | 35 +++
 rtl/baser_window_meter.sv | 63 ++++++
 rtl/baser_test_sequencer.sv | 158 +++++++++++++++
 tb/tb_baser_test_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baser_pkg.sv
// Shared types and helpers for the BASE-R generator/checker test sequencer.
// Holds the FSM state enum, default widths, data-select codes and a saturating add.
package baser_pkg;

  localparam int DEF_SEL_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = 32;

  localparam logic [3:0] SEL_DATA = 4'b0000;
  localparam logic [3:0] SEL_MIX1 = 4'b0001;
  localparam logic [3:0] SEL_MIX2 = 4'b0010;
  localparam logic [3:0] SEL_CTRL = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SNAP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_EVAL   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Sum clipped to the all-ones value of a width-bit counter (width <= 63).
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          width
  );
    logic [63:0] lim;
    logic [63:0] s;
    lim = (64'd1 << width) - 64'd1;
    s   = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/baser_window_meter.sv
// Per-step measurement window: snapshots checker counters, forms modulo deltas,
// judges the step and accumulates invalid blocks with saturation.
// Ports: clk, rst_n, clear, snap, eval, step, block_count, inv_block_count,
//        step_fail, fail, fail_step, err_blocks.
module baser_window_meter
  import baser_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  snap,
  input  logic                  eval,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [CNT_WIDTH-1:0]  block_count,
  input  logic [CNT_WIDTH-1:0]  inv_block_count,
  output logic                  step_fail,
  output logic                  fail,
  output logic [STEP_WIDTH-1:0] fail_step,
  output logic [CNT_WIDTH-1:0]  err_blocks
);

  logic [CNT_WIDTH-1:0] base_blk;
  logic [CNT_WIDTH-1:0] base_inv;
  logic [CNT_WIDTH-1:0] d_blk;
  logic [CNT_WIDTH-1:0] d_inv;

  // Plain subtraction is modulo 2^CNT_WIDTH, so counter wrap is harmless.
  assign d_blk = block_count - base_blk;
  assign d_inv = inv_block_count - base_inv;

  assign step_fail = (d_inv != '0) || (d_blk == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_blk   <= '0;
      base_inv   <= '0;
      fail       <= 1'b0;
      fail_step  <= '0;
      err_blocks <= '0;
    end else if (clear) begin
      fail       <= 1'b0;
      fail_step  <= '0;
      err_blocks <= '0;
    end else begin
      if (snap) begin
        base_blk <= block_count;
        base_inv <= inv_block_count;
      end
      if (eval) begin
        err_blocks <= CNT_WIDTH'(sat_add(64'(err_blocks), 64'(d_inv),
                                         CNT_WIDTH));
        if (step_fail && !fail) begin
          fail      <= 1'b1;
          fail_step <= step;
        end
      end
    end
  end

endmodule

// File: rtl/baser_test_sequencer.sv
// Self-sequencing run controller for the BASE-R generator/257b-checker loop.
// Ports: clk, i_rst_n, i_start/i_abort, run program inputs, checker counters, generator drive and results.
module baser_test_sequencer
  import baser_pkg::*;
#(
  parameter int MAX_STEPS   = 8,
  parameter int SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int DWELL_WIDTH = 16,
  parameter int PIPE_LAT    = 4
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [$clog2(MAX_STEPS):0]       i_num_steps,
  input  logic [MAX_STEPS*SEL_WIDTH-1:0]   i_sel_table,
  input  logic [DWELL_WIDTH-1:0]           i_dwell,
  input  logic [CNT_WIDTH-1:0]             i_block_count,
  input  logic [CNT_WIDTH-1:0]             i_inv_block_count,
  output logic                             o_enable,
  output logic [1:0]                       o_valid,
  output logic [SEL_WIDTH-1:0]             o_data_sel,
  output logic [$clog2(MAX_STEPS)-1:0]     o_step_idx,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_pass,
  output logic                             o_aborted,
  output logic [$clog2(MAX_STEPS)-1:0]     o_fail_step,
  output logic [CNT_WIDTH-1:0]             o_err_blocks
);

  localparam int SW = $clog2(MAX_STEPS);
  localparam int NW = SW + 1;
  localparam int PW = $clog2(PIPE_LAT + 1);

  state_t                         state;
  logic [MAX_STEPS*SEL_WIDTH-1:0] table_r;
  logic [NW-1:0]                  nsteps_r;
  logic [DWELL_WIDTH-1:0]         dwell_r;
  logic [PW-1:0]                  settle_cnt;
  logic [DWELL_WIDTH-1:0]         dwell_cnt;
  logic [SW-1:0]                  step_next;
  logic [NW-1:0]                  nsteps_in;
  logic                           idle_like;
  logic                           start_go;
  logic                           last_step;
  logic                           step_fail;
  logic                           fail;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign start_go  = idle_like && i_start && !i_abort;
  assign step_next = o_step_idx + SW'(1);
  assign last_step = ({1'b0, o_step_idx} == (nsteps_r - NW'(1)));
  assign o_valid   = {2{o_enable}};

  always_comb begin
    nsteps_in = i_num_steps;
    if (i_num_steps == '0)
      nsteps_in = NW'(1);
    else if (i_num_steps > NW'(MAX_STEPS))
      nsteps_in = NW'(MAX_STEPS);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      table_r    <= '0;
      nsteps_r   <= NW'(1);
      dwell_r    <= DWELL_WIDTH'(1);
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      o_enable   <= 1'b0;
      o_data_sel <= '0;
      o_step_idx <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_aborted  <= 1'b0;
    end else if (idle_like) begin
      if (start_go) begin
        table_r    <= i_sel_table;
        nsteps_r   <= nsteps_in;
        dwell_r    <= (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
        settle_cnt <= '0;
        o_step_idx <= '0;
        o_data_sel <= i_sel_table[SEL_WIDTH-1:0];
        o_enable   <= 1'b1;
        o_busy     <= 1'b1;
        o_done     <= 1'b0;
        o_pass     <= 1'b0;
        o_aborted  <= 1'b0;
        state      <= ST_SETTLE;
      end
    end else if (i_abort) begin
      state     <= ST_DONE;
      o_enable  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b1;
      o_pass    <= 1'b0;
      o_aborted <= 1'b1;
    end else begin
      unique case (state)
        ST_SETTLE: begin
          if (settle_cnt == PW'(PIPE_LAT - 1))
            state <= ST_SNAP;
          else
            settle_cnt <= settle_cnt + PW'(1);
        end
        ST_SNAP: begin
          dwell_cnt <= dwell_r;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (dwell_cnt == DWELL_WIDTH'(1))
            state <= ST_EVAL;
          else
            dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
        end
        ST_EVAL: begin
          if (last_step) begin
            state    <= ST_DONE;
            o_enable <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            // The meter's fail flag updates on this same edge.
            o_pass   <= !(fail || step_fail);
          end else begin
            o_step_idx <= step_next;
            o_data_sel <= table_r[step_next*SEL_WIDTH +: SEL_WIDTH];
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  baser_window_meter #(
    .CNT_WIDTH  (CNT_WIDTH),
    .STEP_WIDTH (SW)
  ) u_meter (
    .clk             (clk),
    .rst_n           (i_rst_n),
    .clear           (start_go),
    .snap            ((state == ST_SNAP) && !i_abort),
    .eval            ((state == ST_EVAL) && !i_abort),
    .step            (o_step_idx),
    .block_count     (i_block_count),
    .inv_block_count (i_inv_block_count),
    .step_fail       (step_fail),
    .fail            (fail),
    .fail_step       (o_fail_step),
    .err_blocks      (o_err_blocks)
  );

endmodule

// File: tb/tb_baser_test_sequencer.sv
// Directed bench for baser_test_sequencer with a checker-counter model
// and a scoreboard of expected run results.
module tb_baser_test_sequencer;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [3:0]  i_num_steps;
  logic [31:0] i_sel_table;
  logic [15:0] i_dwell;
  logic [31:0] i_block_count;
  logic [31:0] i_inv_block_count;
  logic        o_enable;
  logic [1:0]  o_valid;
  logic [3:0]  o_data_sel;
  logic [2:0]  o_step_idx;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic        o_aborted;
  logic [2:0]  o_fail_step;
  logic [31:0] o_err_blocks;

  always #5 clk = ~clk;

  baser_test_sequencer dut (
    .clk               (clk),
    .i_rst_n           (i_rst_n),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_num_steps       (i_num_steps),
    .i_sel_table       (i_sel_table),
    .i_dwell           (i_dwell),
    .i_block_count     (i_block_count),
    .i_inv_block_count (i_inv_block_count),
    .o_enable          (o_enable),
    .o_valid           (o_valid),
    .o_data_sel        (o_data_sel),
    .o_step_idx        (o_step_idx),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_pass            (o_pass),
    .o_aborted         (o_aborted),
    .o_fail_step       (o_fail_step),
    .o_err_blocks      (o_err_blocks)
  );

  typedef struct {
    string tag;
    bit    pass;
    int    fail_step;
    int    err;
    int    cycles;
    bit    aborted;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] sel_seen[$];
  int         max_step;
  int         errors = 0;
  int         checks = 0;
  bit         blk_en;
  int         run_cyc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; checker model advances its block counter after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (blk_en) i_block_count = i_block_count + 32'd1;
  endtask

  function automatic int eff_n(input int n);
    return (n == 0) ? 1 : ((n > 8) ? 8 : n);
  endfunction

  function automatic int run_len(input int n, input int d);
    return eff_n(n) * (4 + 1 + ((d == 0) ? 1 : d) + 1);
  endfunction

  task automatic run(input int n, input logic [31:0] tbl, input int d,
                     input int inj_at, input int inj_amt,
                     input int stall_until, input int abort_at,
                     input int bound, output int k);
    logic [3:0] last_sel;
    i_num_steps = 4'(n);
    i_sel_table = tbl;
    i_dwell     = 16'(d);
    i_start     = 1'b1;
    blk_en      = (stall_until <= 0);
    tick();
    i_start = 1'b0;
    k = 0;
    sel_seen.delete();
    max_step = 0;
    last_sel = o_data_sel;
    sel_seen.push_back(last_sel);
    while (!o_done && k < bound) begin
      i_abort = (k == abort_at);
      blk_en  = (k >= stall_until);
      tick();
      k++;
      i_abort = 1'b0;
      if (k == inj_at) i_inv_block_count = i_inv_block_count + 32'(inj_amt);
      if (o_busy && o_data_sel != last_sel) begin
        last_sel = o_data_sel;
        sel_seen.push_back(last_sel);
      end
      if (o_busy && int'(o_step_idx) > max_step) max_step = int'(o_step_idx);
    end
    blk_en = 1'b1;
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_done"}, 64'(o_done), 64'd1);
      chk({e.tag, "_cycles"}, 64'(run_cyc), 64'(e.cycles));
      chk({e.tag, "_pass"}, 64'(o_pass), 64'(e.pass));
      chk({e.tag, "_fail_step"}, 64'(o_fail_step), 64'(e.fail_step));
      chk({e.tag, "_err"}, 64'(o_err_blocks), 64'(e.err));
      chk({e.tag, "_aborted"}, 64'(o_aborted), 64'(e.aborted));
      chk({e.tag, "_idle_drive"},
          64'({o_enable, o_valid, o_busy}), 64'd0);
    end
  endtask

  initial begin
    i_rst_n           = 1'b0;
    i_start           = 1'b0;
    i_abort           = 1'b0;
    i_num_steps       = '0;
    i_sel_table       = '0;
    i_dwell           = '0;
    i_block_count     = 32'd100;
    i_inv_block_count = 32'd7;
    blk_en            = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", 64'({o_enable, o_valid, o_data_sel, o_step_idx,
        o_busy, o_done, o_pass, o_aborted, o_fail_step}), 64'd0);
    chk("rst_err", 64'(o_err_blocks), 64'd0);
    i_rst_n = 1'b1;
    tick();

    // Nominal three-step run; also checks first-cycle drive.
    sb.push_back('{"nominal", 1'b1, 0, 0, run_len(3, 20), 1'b0});
    i_num_steps = 4'd3;
    i_sel_table = 32'h0000_0F21;
    i_dwell     = 16'd20;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_enable", 64'(o_enable), 64'd1);
    chk("start_valid", 64'(o_valid), 64'd3);
    chk("start_busy", 64'(o_busy), 64'd1);
    begin
      logic [3:0] last_sel;
      int k;
      k = 0;
      sel_seen.delete();
      last_sel = o_data_sel;
      sel_seen.push_back(last_sel);
      while (!o_done && k < 200) begin
        tick();
        k++;
        if (o_busy && o_data_sel != last_sel) begin
          last_sel = o_data_sel;
          sel_seen.push_back(last_sel);
        end
      end
      run_cyc = k;
    end
    check_result();
    chk("sel_count", 64'(sel_seen.size()), 64'd3);
    if (sel_seen.size() == 3) begin
      chk("sel0", 64'(sel_seen[0]), 64'd1);
      chk("sel1", 64'(sel_seen[1]), 64'd2);
      chk("sel2", 64'(sel_seen[2]), 64'd15);
    end
    chk("sel_hold", 64'(o_data_sel), 64'd15);

    // Three invalid blocks inside step 1's measured window.
    sb.push_back('{"err_step1", 1'b0, 1, 3, run_len(3, 20), 1'b0});
    run(3, 32'h0000_0F21, 20, 40, 3, 0, -1, 200, run_cyc);
    check_result();

    // Block counter frozen through step 0.
    sb.push_back('{"stall", 1'b0, 0, 0, run_len(2, 20), 1'b0});
    run(2, 32'h0000_0021, 20, -1, 0, 28, -1, 200, run_cyc);
    check_result();

    // Block counter wraps inside the window.
    i_block_count = 32'hFFFF_FFF0;
    sb.push_back('{"wrap", 1'b1, 0, 0, run_len(1, 32), 1'b0});
    run(1, 32'h0000_0001, 32, -1, 0, 0, -1, 200, run_cyc);
    check_result();

    // Abort during step 1 RUN.
    sb.push_back('{"abort", 1'b0, 0, 0, 39, 1'b1});
    run(3, 32'h0000_0F21, 20, -1, 0, 0, 38, 200, run_cyc);
    check_result();
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("startabort_done", 64'(o_done), 64'd1);
    chk("startabort_busy", 64'(o_busy), 64'd0);
    chk("startabort_aborted", 64'(o_aborted), 64'd1);
    tick();
    chk("startabort_enable", 64'(o_enable), 64'd0);

    // Zero steps and zero dwell: one step of a single RUN cycle.
    sb.push_back('{"zero", 1'b1, 0, 0, run_len(0, 0), 1'b0});
    run(0, 32'h0000_0003, 0, -1, 0, 0, -1, 100, run_cyc);
    check_result();

    // Step count above MAX_STEPS clamps to 8.
    sb.push_back('{"clamp", 1'b1, 0, 0, run_len(15, 2), 1'b0});
    run(15, 32'h7654_3210, 2, -1, 0, 0, -1, 200, run_cyc);
    check_result();
    chk("clamp_max_step", 64'(max_step), 64'd7);

    // Asynchronous reset mid-RUN.
    i_num_steps = 4'd2;
    i_sel_table = 32'h0000_0021;
    i_dwell     = 16'd20;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", 64'({o_enable, o_valid, o_data_sel,
        o_step_idx, o_busy, o_done, o_pass, o_aborted, o_fail_step}), 64'd0);
    chk("midrun_rst_err", 64'(o_err_blocks), 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'({o_busy, o_done}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
